// File: rtl/cpu_fetch_if.sv
// Instruction-memory read bus between the fetch stage and memory.
// Master side issues requests; slave side acks with read data.
interface cpu_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/cpu_fetch.sv
// Fetch stage 1a: assembles 48-bit big-endian instructions for decode.
// Define CPU_FETCH_STATS_EN to add bubble/kill counters.
module cpu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        stall_2a,
  input  logic        kill_4a,
  input  logic [31:0] branch_target_4a,
  output logic [47:0] instruction_1a,
  output logic [31:0] pc_1a,
`ifdef CPU_FETCH_STATS_EN
  output logic [31:0] stat_bubbles,
  output logic [31:0] stat_kills,
`endif
  cpu_fetch_if.master imem
);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t      state_q, state_d;
  logic        live_q;
  logic        pend_q, pend_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  logic [63:0] buf_q, buf_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] head_q, head_d;
  logic [31:0] fetch_q, fetch_d;
  logic        skip_q, skip_d;
  logic [47:0] instr_d;
  logic [31:0] pc_d;

  logic        issue, ack, consume, bubble;
  logic [63:0] shifted, ins;
  logic [2:0]  base;

  assign issue = live_q & (state_q == RUN) & ~pend_q
               & (cnt_q <= 3'd2);

  assign imem.imem_req  = pend_q | issue;
  assign imem.imem_addr = pend_q ? pend_addr_q : fetch_q;

  assign ack     = imem.imem_req & imem.imem_ack;
  assign consume = ~kill_4a & ~stall_2a & (cnt_q >= 3'd3);
  assign bubble  = ~kill_4a & ~stall_2a & (cnt_q < 3'd3);

  always_comb begin
    state_d     = state_q;
    pend_d      = imem.imem_req & ~ack;
    pend_addr_d = imem.imem_addr;
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    head_d      = head_q;
    fetch_d     = fetch_q;
    skip_d      = skip_q;
    instr_d     = instruction_1a;
    pc_d        = pc_1a;
    shifted     = buf_q;
    base        = cnt_q;
    ins         = '0;

    if (consume) begin
      shifted = buf_q << 48;
      base    = cnt_q - 3'd3;
    end

    // Appended data lands just behind whatever survives the shift.
    if (skip_q)
      ins = {imem.imem_rdata[15:0], 48'h0} >> {base, 4'h0};
    else
      ins = {imem.imem_rdata, 32'h0} >> {base, 4'h0};

    unique case (1'b1)
      kill_4a: begin
        instr_d = '0;
        pc_d    = branch_target_4a;
      end
      consume: begin
        instr_d = buf_q[63:16];
        pc_d    = head_q;
        head_d  = {head_q[31:1] + 31'd3, head_q[0]};
      end
      bubble: begin
        instr_d = '0;
        pc_d    = head_q;
      end
      default: ;
    endcase

    if (kill_4a) begin
      buf_d   = '0;
      cnt_d   = '0;
      head_d  = branch_target_4a;
      fetch_d = {branch_target_4a[31:2], 2'b00};
      skip_d  = branch_target_4a[1];
      state_d = (imem.imem_req & ~ack) ? DRAIN : RUN;
    end else begin
      buf_d = shifted;
      cnt_d = base;
      if (ack && state_q == RUN) begin
        buf_d   = shifted | ins;
        cnt_d   = base + (skip_q ? 3'd1 : 3'd2);
        fetch_d = fetch_q + 32'd4;
        skip_d  = 1'b0;
      end
      if (ack && state_q == DRAIN)
        state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q        <= RUN;
      live_q         <= 1'b0;
      pend_q         <= 1'b0;
      pend_addr_q    <= '0;
      buf_q          <= '0;
      cnt_q          <= '0;
      head_q         <= RESET_PC;
      fetch_q        <= {RESET_PC[31:2], 2'b00};
      skip_q         <= RESET_PC[1];
      instruction_1a <= '0;
      pc_1a          <= RESET_PC;
    end else begin
      state_q        <= state_d;
      live_q         <= 1'b1;
      pend_q         <= pend_d;
      pend_addr_q    <= pend_addr_d;
      buf_q          <= buf_d;
      cnt_q          <= cnt_d;
      head_q         <= head_d;
      fetch_q        <= fetch_d;
      skip_q         <= skip_d;
      instruction_1a <= instr_d;
      pc_1a          <= pc_d;
    end
  end

`ifdef CPU_FETCH_STATS_EN
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      stat_bubbles <= '0;
      stat_kills   <= '0;
    end else begin
      if (bubble && stat_bubbles != 32'hFFFF_FFFF)
        stat_bubbles <= stat_bubbles + 32'd1;
      if (kill_4a && stat_kills != 32'hFFFF_FFFF)
        stat_kills <= stat_kills + 32'd1;
    end
  end
`endif

endmodule

// File: doc/cpu_fetch.md
Name: cpu_fetch

Overview:
- Front-end stage 1a. Producer side of the fetch/decode interface: supplies instruction_1a/pc_1a to decode and honours its stall_2a backpressure.
- Fetches 32-bit words from instruction memory and assembles big-endian 48-bit instructions at halfword-aligned byte addresses.
- Redirects on kill_4a to branch_target_4a.
- Presents a NOP bubble (48'h0) to decode whenever no complete instruction is ready.

Parameters:
- RESET_PC, 32'h0000_0000, pc loaded at reset; bit0 is the js_mode flag.

Ports:
- clk  input  1  clock
- rst_b  input  1  reset, asynchronous, active-low
- stall_2a  input  1  decode is not consuming; hold instruction_1a/pc_1a
- kill_4a  input  1  flush the front end and redirect
- branch_target_4a  input  32  redirect pc; bit0 = js_mode
- instruction_1a  output  48  registered instruction; [47:40] is the opcode
- pc_1a  output  32  registered pc of instruction_1a
- imem_req  output  1  memory read request
- imem_addr  output  32  word address, [1:0]=0
- imem_ack  input  1  request complete; imem_rdata valid this cycle
- imem_rdata  input  32  big-endian; lowest byte address in [31:24]

Behaviour:
- Reset:
  - instruction_1a=0, pc_1a=RESET_PC, imem_req=0.
  - Buffer empty, head_pc=RESET_PC, fetch_addr={RESET_PC[31:2],2'b00}, skip=RESET_PC[1].
  - State RUN.
  - Reset mid-transaction abandons it. Memory must tolerate this.
- Buffer:
  - 64-bit halfword queue, hw_count 0..4.
  - Head halfword is at byte address {head_pc[31:1],1'b0}.
- Memory protocol:
  - At most one outstanding request.
  - imem_req and imem_addr stay stable from assertion until the cycle imem_ack=1. The transfer completes in that cycle.
  - ack may arrive in the same cycle as req.
  - imem_ack without an outstanding request is ignored.
- Request issue (RUN): assert when no request is outstanding and hw_count<=2. The count is taken at cycle start, ignoring same-cycle consumption.
- On ack in RUN:
  - Append the word at position hw_count; hw_count+=2.
  - If skip=1, drop the upper halfword [31:16], append [15:0] only (hw_count+=1), then clear skip.
  - fetch_addr+=4.
- Consume: when stall_2a=0 and kill_4a=0, register the 1a outputs:
  - If hw_count>=3 at cycle start: instruction_1a=top 48 bits, pc_1a=head_pc, shift out 3 halfwords.
  - head_pc+=6 on bits [31:1] with bit0 preserved, so js_mode is sticky until redirect.
  - Otherwise instruction_1a=48'h0 and pc_1a=head_pc (bubble); buffer unchanged.
- stall_2a=1: instruction_1a/pc_1a hold. Buffer may still fill.
- Simultaneous consume and append: hw_count_next = hw_count - 3 + (1 or 2). Data appends after the shift.
- kill_4a=1 (priority over stall and consume):
  - instruction_1a=0, pc_1a=branch_target_4a, buffer flushed (hw_count=0).
  - head_pc=branch_target_4a, fetch_addr={target[31:2],2'b00}, skip=target[1].
  - If a request is outstanding and not acked this cycle, go to DRAIN.
  - If acked this cycle, discard the data and stay in RUN.
- DRAIN:
  - imem_req stays high with the old address until ack. Data is discarded.
  - No new request issues. Then go to RUN; the first request can issue the next cycle.
  - A further kill in DRAIN updates the redirect registers and remains in DRAIN.
- Wrap-around: fetch_addr and head_pc wrap modulo 2^32.

Optional Feature:
- Macro: CPU_FETCH_STATS_EN.
- Defined:
  - Adds outputs stat_bubbles[31:0] and stat_kills[31:0], reset to 0, saturating at 32'hFFFF_FFFF.
  - stat_bubbles increments on each unstalled, unkilled cycle that emits a bubble.
  - stat_kills increments on each kill_4a cycle.
- Undefined: ports and logic are absent. Behaviour is otherwise identical.

Test Plan:
- Reset, RESET_PC=0, memory returns 0x11223344 and then 0x55667788 with 0-cycle ack, stall_2a=0 -> bubbles, then instruction_1a=48'h112233445566 with pc_1a=0. Next instruction starts at pc 6 (bytes 77,88,...).
- Kill with target 0x00000102 -> first request imem_addr=0x100, upper halfword dropped. instruction_1a holds bytes 0x102..0x107 with pc_1a=0x102; subsequent pc_1a=0x108 (bit0=0).
- Target 0x00000201 (js_mode) -> pc_1a sequence 0x201, 0x207, 0x20D; bit0 stays 1.
- stall_2a held 5 cycles with a full buffer -> instruction_1a/pc_1a constant, at most 2 acks accepted (hw_count<=4), no data lost after release.
- kill_4a while a request to 0x40 is pending, ack 3 cycles later -> imem_addr stays 0x40 until ack, data discarded, next imem_addr=target word, no stale instruction reaches instruction_1a.
- kill_4a and stall_2a asserted together -> instruction_1a=0 and pc_1a=target next cycle regardless of stall.
